// File: rtl/thor2025_pkg.sv
// rtl/thor2025_pkg.sv - shared types and sizing for the Thor2025 rename stage
package thor2025_pkg;
  localparam int NPREG = 96;
  localparam int NRSVD = 1;
  localparam int NFREE = 4;
  localparam int TW    = $clog2(NPREG);

  typedef logic [TW-1:0] pregno_t;

  // Reserved tags start out allocated and stay that way.
  localparam logic [NPREG-1:0] FREE_MAP_RST = {{(NPREG-NRSVD){1'b1}}, {NRSVD{1'b0}}};
endpackage

// File: rtl/thor2025_find3.sv
// rtl/thor2025_find3.sv - three lowest set bits of a bitmap, ascending
module thor2025_find3
  import thor2025_pkg::*;
(
  input  logic [NPREG-1:0] map,
  output logic [TW-1:0]    tag0,
  output logic [TW-1:0]    tag1,
  output logic [TW-1:0]    tag2,
  output logic [2:0]       found
);
  logic [NPREG-1:0] m1;
  logic [NPREG-1:0] m2;

  function automatic logic [TW-1:0] lsb_idx(input logic [NPREG-1:0] m);
    lsb_idx = '0;
    for (int i = NPREG - 1; i >= 0; i--) begin
      if (m[i]) lsb_idx = TW'(i);
    end
  endfunction

  // m & (m - 1) drops the lowest set bit, so each stage sees only what is left.
  always_comb begin
    m1    = map & (map - NPREG'(1));
    m2    = m1 & (m1 - NPREG'(1));
    tag0  = lsb_idx(map);
    tag1  = lsb_idx(m1);
    tag2  = lsb_idx(m2);
    found = {|m2, |m1, |map};
  end
endmodule

// File: rtl/thor2025_preg_alloc.sv
// rtl/thor2025_preg_alloc.sv - Thor2025 physical-register allocator
module thor2025_preg_alloc
  import thor2025_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          alloc_req,
  output logic                alloc_rdy,
  output logic [3*TW-1:0]     alloc_tag,
  input  logic [NFREE-1:0]    free_v,
  input  logic [NFREE*TW-1:0] free_tag,
  output logic [TW-1:0]       free_cnt,
  output logic                err
);
  logic [NPREG-1:0]   free_map_q, free_map_d;
  logic [TW-1:0]      free_cnt_q, free_cnt_d;
  logic               err_q, err_d;
  pregno_t            tag0, tag1, tag2;
  logic [2:0]         found;
  logic               grant;
  pregno_t            ftag [NFREE];
  logic [NFREE-1:0]   acc;
  logic [2:0]         n_acc;
  logic [TW:0]        cnt_sum;
  logic [(1<<TW)-1:0] map_ext;
  logic [NPREG-1:0]   clr_mask, set_mask;

  thor2025_find3 u_find3 (
    .map   (free_map_q),
    .tag0  (tag0),
    .tag1  (tag1),
    .tag2  (tag2),
    .found (found)
  );

  assign alloc_tag = {tag2, tag1, tag0};
  assign alloc_rdy = free_cnt_q >= {{(TW-2){1'b0}}, alloc_req};
  assign free_cnt  = free_cnt_q;
  assign err       = err_q;

  // A free is accepted only for an in-range, currently allocated tag not already
  // claimed by a lower port; a tag being granted is still free, so it loses here.
  always_comb begin
    map_ext              = '0;
    map_ext[NPREG-1:0]   = free_map_q;
    acc                  = '0;
    n_acc                = '0;
    set_mask             = '0;
    for (int p = 0; p < NFREE; p++) begin
      ftag[p] = free_tag[p*TW +: TW];
      acc[p]  = free_v[p] && (ftag[p] >= TW'(NRSVD)) && (ftag[p] < TW'(NPREG))
                && !map_ext[ftag[p]];
      for (int q = 0; q < p; q++) begin
        if (free_v[q] && (ftag[q] == ftag[p])) acc[p] = 1'b0;
      end
      if (acc[p]) begin
        set_mask[ftag[p]] = 1'b1;
        n_acc             = n_acc + 3'd1;
      end
    end
  end

  always_comb begin
    grant    = (alloc_req != 2'd0) && alloc_rdy;
    clr_mask = '0;
    if (grant) begin
      if (found[0]) clr_mask[tag0] = 1'b1;
      if (found[1] && (alloc_req >= 2'd2)) clr_mask[tag1] = 1'b1;
      if (found[2] && (alloc_req == 2'd3)) clr_mask[tag2] = 1'b1;
    end
    free_map_d = (free_map_q & ~clr_mask) | set_mask;
    cnt_sum    = {1'b0, free_cnt_q} + {{(TW-2){1'b0}}, n_acc}
                 - (grant ? {{(TW-1){1'b0}}, alloc_req} : {(TW+1){1'b0}});
    // Grants never exceed the count, so the borrow bit only guards against wrap.
    free_cnt_d = cnt_sum[TW] ? '0 : cnt_sum[TW-1:0];
    err_d      = err_q | (|(free_v & ~acc));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map_q <= FREE_MAP_RST;
      free_cnt_q <= TW'(NPREG - NRSVD);
      err_q      <= 1'b0;
    end else begin
      free_map_q <= free_map_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_thor2025_preg_alloc.sv
// tb/tb_thor2025_preg_alloc.sv - self-checking bench for thor2025_preg_alloc
module tb_thor2025_preg_alloc;
  import thor2025_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          alloc_req;
  logic                alloc_rdy;
  logic [3*TW-1:0]     alloc_tag;
  logic [NFREE-1:0]    free_v;
  logic [NFREE*TW-1:0] free_tag;
  logic [TW-1:0]       free_cnt;
  logic                err;

  int vectors = 0;
  int miscompares = 0;

  bit mfree [NPREG];
  int mcnt;
  bit merr;
  int exp_tag [3];

  always #5 clk = ~clk;

  thor2025_preg_alloc dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_rdy (alloc_rdy),
    .alloc_tag (alloc_tag),
    .free_v    (free_v),
    .free_tag  (free_tag),
    .free_cnt  (free_cnt),
    .err       (err)
  );

  function automatic int got_tag(int k);
    return int'(alloc_tag[k*TW +: TW]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NPREG; i++) mfree[i] = (i >= NRSVD);
    mcnt = NPREG - NRSVD;
    merr = 1'b0;
  endfunction

  function automatic void model_tags();
    int n = 0;
    exp_tag = '{0, 0, 0};
    for (int i = 0; i < NPREG; i++) begin
      if (mfree[i] && n < 3) begin
        exp_tag[n] = i;
        n++;
      end
    end
  endfunction

  function automatic void model_edge();
    bit seen [NPREG];
    int acc = 0;
    int ng;
    int t;
    model_tags();
    ng = (alloc_req != 0 && mcnt >= int'(alloc_req)) ? int'(alloc_req) : 0;
    for (int p = 0; p < NFREE; p++) begin
      if (free_v[p]) begin
        t = int'(free_tag[p*TW +: TW]);
        if (t < NRSVD || t >= NPREG) merr = 1'b1;
        else if (mfree[t] || seen[t]) merr = 1'b1;
        else begin
          seen[t] = 1'b1;
          acc++;
        end
      end
    end
    for (int k = 0; k < ng; k++) mfree[exp_tag[k]] = 1'b0;
    for (int i = 0; i < NPREG; i++) if (seen[i]) mfree[i] = 1'b1;
    mcnt = mcnt + acc - ng;
  endfunction

  task automatic drive(input int req, input bit [3:0] fv, input int t0, t1, t2, t3);
    alloc_req = 2'(req);
    free_v    = fv;
    free_tag  = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    drive(0, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 4'b0000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    drive(3, 4'b0000, 0, 0, 0, 0);
    #2;
    vectors++; if (free_cnt !== 7'd95) begin miscompares++; $display("FAIL reset_cnt got %0d want 95", free_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err); end
    vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %0b want 1", alloc_rdy); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (got_tag(k) != k + 1) begin miscompares++; $display("FAIL reset_tag%0d got %0d want %0d", k, got_tag(k), k + 1); end
    end
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd92) begin miscompares++; $display("FAIL first_grant_cnt got %0d want 92", free_cnt); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (got_tag(k) != k + 4) begin miscompares++; $display("FAIL first_grant_tag%0d got %0d want %0d", k, got_tag(k), k + 4); end
    end
  endtask

  task automatic test_exhaust();
    int want;
    do_reset();
    for (int g = 0; g < 32; g++) begin
      drive(g < 31 ? 3 : 2, 4'b0000, 0, 0, 0, 0);
      #2;
      vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL exhaust_rdy g=%0d got %0b want 1", g, alloc_rdy); end
      for (int k = 0; k < 3; k++) begin
        want = (1 + 3 * g + k <= NPREG - 1) ? 1 + 3 * g + k : 0;
        vectors++; if (got_tag(k) != want) begin miscompares++; $display("FAIL exhaust_tag g=%0d k=%0d got %0d want %0d", g, k, got_tag(k), want); end
      end
      tick();
    end
    drive(0, 4'b0000, 0, 0, 0, 0);
    #2;
    vectors++; if (free_cnt !== 7'd0) begin miscompares++; $display("FAIL empty_cnt got %0d want 0", free_cnt); end
    vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL empty_rdy_req0 got %0b want 1", alloc_rdy); end
    drive(1, 4'b0000, 0, 0, 0, 0);
    #2;
    vectors++; if (alloc_rdy !== 1'b0) begin miscompares++; $display("FAIL empty_rdy_req1 got %0b want 0", alloc_rdy); end
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd0) begin miscompares++; $display("FAIL empty_stall_cnt got %0d want 0", free_cnt); end
    vectors++; if (got_tag(0) != 0) begin miscompares++; $display("FAIL empty_tag0 got %0d want 0", got_tag(0)); end
  endtask

  task automatic test_stall_then_free();
    drive(0, 4'b0011, 7, 60, 0, 0);
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd2) begin miscompares++; $display("FAIL stall_cnt2 got %0d want 2", free_cnt); end
    drive(3, 4'b0001, 33, 0, 0, 0);
    #2;
    vectors++; if (alloc_rdy !== 1'b0) begin miscompares++; $display("FAIL stall_rdy got %0b want 0", alloc_rdy); end
    tick();
    drive(3, 4'b0000, 0, 0, 0, 0);
    #2;
    vectors++; if (free_cnt !== 7'd3) begin miscompares++; $display("FAIL stall_cnt3 got %0d want 3", free_cnt); end
    vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL stall_rdy_after got %0b want 1", alloc_rdy); end
    vectors++; if (alloc_tag !== {7'd60, 7'd33, 7'd7}) begin miscompares++; $display("FAIL stall_tags got %0d,%0d,%0d want 7,33,60", got_tag(0), got_tag(1), got_tag(2)); end
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd0) begin miscompares++; $display("FAIL stall_drain got %0d want 0", free_cnt); end
  endtask

  task automatic test_free_latency();
    drive(0, 4'b0001, 40, 0, 0, 0);
    #2;
    vectors++; if (got_tag(0) != 0) begin miscompares++; $display("FAIL bypass_tag0 got %0d want 0", got_tag(0)); end
    tick();
    drive(1, 4'b0000, 0, 0, 0, 0);
    #2;
    vectors++; if (got_tag(0) != 40) begin miscompares++; $display("FAIL reuse_tag0 got %0d want 40", got_tag(0)); end
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd0) begin miscompares++; $display("FAIL reuse_cnt got %0d want 0", free_cnt); end
  endtask

  task automatic test_multi_free();
    drive(0, 4'b0011, 5, 6, 0, 0);
    tick();
    drive(2, 4'b1111, 10, 20, 30, 40);
    #2;
    vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL multi_rdy got %0b want 1", alloc_rdy); end
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd4) begin miscompares++; $display("FAIL multi_cnt got %0d want 4", free_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL multi_err got %0b want 0", err); end
    vectors++; if (alloc_tag !== {7'd30, 7'd20, 7'd10}) begin miscompares++; $display("FAIL multi_tags got %0d,%0d,%0d want 10,20,30", got_tag(0), got_tag(1), got_tag(2)); end
  endtask

  task automatic test_errors();
    drive(0, 4'b0001, 0, 0, 0, 0);
    tick();
    #2;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_rsvd got %0b want 1", err); end
    vectors++; if (free_cnt !== 7'd4) begin miscompares++; $display("FAIL err_rsvd_cnt got %0d want 4", free_cnt); end
    drive(0, 4'b0001, 50, 0, 0, 0);
    tick();
    drive(0, 4'b0001, 50, 0, 0, 0);
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd5) begin miscompares++; $display("FAIL err_double_cnt got %0d want 5", free_cnt); end
    drive(0, 4'b0101, 60, 0, 60, 0);
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd6) begin miscompares++; $display("FAIL err_dup_cnt got %0d want 6", free_cnt); end
    drive(0, 4'b1000, 0, 0, 0, 100);
    tick();
    tick();
    #2;
    vectors++; if (free_cnt !== 7'd6) begin miscompares++; $display("FAIL err_range_cnt got %0d want 6", free_cnt); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %0b want 1", err); end
    do_reset();
    #2;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared got %0b want 0", err); end
    drive(1, 4'b0001, 1, 0, 0, 0);
    tick();
    #2;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL alloc_free_err got %0b want 1", err); end
    vectors++; if (free_cnt !== 7'd94) begin miscompares++; $display("FAIL alloc_free_cnt got %0d want 94", free_cnt); end
    vectors++; if (got_tag(0) != 2) begin miscompares++; $display("FAIL alloc_free_tag0 got %0d want 2", got_tag(0)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(3, 4'b0000, 0, 0, 0, 0);
    tick();
    drive(3, 4'b0000, 0, 0, 0, 0);
    tick();
    drive(3, 4'b0001, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (free_cnt !== 7'd95) begin miscompares++; $display("FAIL async_cnt got %0d want 95", free_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL async_err got %0b want 0", err); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(3, 4'b0000, 0, 0, 0, 0);
    #2;
    vectors++; if (alloc_tag !== {7'd3, 7'd2, 7'd1}) begin miscompares++; $display("FAIL async_tags got %0d,%0d,%0d want 1,2,3", got_tag(0), got_tag(1), got_tag(2)); end
    vectors++; if (free_cnt !== 7'd95) begin miscompares++; $display("FAIL async_cnt_after got %0d want 95", free_cnt); end
  endtask

  task automatic test_random();
    int req;
    bit [3:0] fv;
    int t [4];
    int used_q [$];
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      used_q.delete();
      for (int j = NRSVD; j < NPREG; j++) if (!mfree[j]) used_q.push_back(j);
      req = (mcnt < 12) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      for (int p = 0; p < 4; p++) begin
        fv[p] = ($urandom_range(0, 99) < 35);
        if (used_q.size() > 0 && $urandom_range(0, 99) < 90)
          t[p] = used_q[$urandom_range(0, used_q.size() - 1)];
        else
          t[p] = $urandom_range(0, 127);
      end
      drive(req, fv, t[0], t[1], t[2], t[3]);
      #2;
      model_tags();
      vectors++; if (alloc_rdy !== (mcnt >= req)) begin miscompares++; $display("FAIL rand_rdy i=%0d got %0b want %0b", i, alloc_rdy, mcnt >= req); end
      for (int k = 0; k < 3; k++) begin
        vectors++; if (got_tag(k) != exp_tag[k]) begin miscompares++; $display("FAIL rand_tag i=%0d k=%0d got %0d want %0d", i, k, got_tag(k), exp_tag[k]); end
      end
      vectors++; if (int'(free_cnt) != mcnt) begin miscompares++; $display("FAIL rand_cnt i=%0d got %0d want %0d", i, free_cnt, mcnt); end
      vectors++; if (err !== merr) begin miscompares++; $display("FAIL rand_err i=%0d got %0b want %0b", i, err, merr); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 4'b0000, 0, 0, 0, 0);
    test_reset();
    test_exhaust();
    test_stall_then_free();
    test_free_latency();
    test_multi_free();
    test_errors();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/thor2025_preg_alloc.md
# thor2025_preg_alloc

Physical-register allocator for the Thor2025 rename stage. It keeps a free bitmap and a free count for the NPREG physical registers. It hands out up to three target tags per cycle to the renamer as an all-or-nothing grant, and it reclaims tags returned by commit and by branch-miss recovery. The granted tags feed the target-allocate inputs of the register-valid tracker, and the freed tags feed its tags-to-free inputs.

## Interface
- NPREG, 96: physical registers; tag width TW = $clog2(NPREG) = 7.
- NRSVD, 1: tags 0..NRSVD-1 are permanently allocated and never granted or freed.
- NFREE, 4: free ports per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- alloc_req  in  2  number of tags requested this cycle (0..3).
- alloc_rdy  out  1  request can be satisfied this cycle.
- alloc_tag  out  3×TW  granted tags, slots 0..2; slot k is meaningful when k < alloc_req.
- free_v  in  NFREE  per-port free strobe.
- free_tag  in  NFREE×TW  tags being returned.
- free_cnt  out  TW  registered count of free tags.
- err  out  1  sticky protocol-error flag.

## Operation
- State:
  - free_map[NPREG-1:0]: 1 means free.
  - free_cnt.
  - err.
- Reset:
  - free_map = 1 for tags NRSVD..NPREG-1, 0 otherwise.
  - free_cnt = NPREG-NRSVD (95).
  - err = 0.
- Tag selection (combinational from registered free_map):
  - alloc_tag[0..2] are the three lowest-numbered free tags, ascending.
  - Unused slots read 0.
- Grant:
  - alloc_rdy = (free_cnt >= alloc_req).
  - A grant occurs when alloc_req != 0 and alloc_rdy = 1.
  - On a grant, slots 0..alloc_req-1 are cleared in free_map at the next edge.
  - Partial grants never occur. When alloc_rdy = 0 the renamer stalls and state is unchanged by allocation.
- Free:
  - For each port with free_v set, tag >= NRSVD, tag < NPREG, and free_map[tag] = 0: set free_map[tag] at the next edge.
  - A tag freed at edge N is allocatable from cycle N+1. There is no same-cycle bypass.
- Count:
  - free_cnt_next = free_cnt + accepted frees - granted count.
  - Evaluated in TW+1 bits; never exceeds NPREG-NRSVD.
- Error cases: each of the following sets err (sticky until rst) and is otherwise ignored, contributing nothing to the count:
  - Freeing a tag that is already free.
  - Freeing a reserved tag.
  - Freeing a tag >= NPREG.
  - Two ports freeing the same tag in one cycle; the first port is accepted and the rest are flagged.
- Simultaneous alloc and free of the same tag: impossible in legal use, because a tag being freed is not free. If it occurs anyway, the free is treated as a double free: it is flagged and the allocation wins.

## Timing
- alloc_rdy and alloc_tag are combinational from registers only, with no path from alloc_req to alloc_tag.
  - The only path from alloc_req is alloc_req → alloc_rdy, a comparison.
- Grant-to-bitmap-update latency: 1 cycle.
- Free-to-reuse latency: 1 cycle.
- free_cnt updates 1 cycle after the grant or free edge.
- Empty boundary: free_cnt = 0 gives alloc_rdy = 1 only for alloc_req = 0.
- Full boundary: free_cnt = NPREG-NRSVD means further frees are all errors.
- Reset asserted mid-operation: asynchronous return to the reset state. Any grant in that cycle is discarded.

## Structure
- Shared package thor2025_pkg holds:
  - typedef pregno_t (logic [6:0]).
  - Constants NPREG and NRSVD.
- Sub-module thor2025_find3(map → tag0..tag2, found[2:0]): a three-deep lowest-set-bit chain, where each stage masks the bit found by the previous stage.
- Everything else (bitmap, counter, error logic) lives in thor2025_preg_alloc.

## Test plan
- Reset, then alloc_req = 3 → alloc_rdy = 1, tags 1, 2, 3; next cycle free_cnt = 92 and tags 4, 5, 6 are offered.
- Allocate 95 tags (31 grants of 3, then 1 grant of 2) → free_cnt = 0; alloc_req = 1 gives alloc_rdy = 0 and state is unchanged.
- free_cnt = 2, alloc_req = 3 → alloc_rdy = 0, no tags consumed. Free one tag the same cycle → free_cnt = 3 next cycle and the request is granted.
- Free tag 40 at cycle N (tag 40 is the lowest free tag) → alloc_tag[0] = 40 at cycle N+1, not at N.
- Four ports free tags 10, 20, 30, 40 while alloc_req = 2 → free_cnt changes by +2; err = 0.
- Free tag 0, then double-free tag 50, then the same tag on two ports → err = 1 after the first event, free_cnt unaffected by the bad frees, err held until rst.
